// File: rtl/pwm_bank_if.sv
// Control/output bundle of pwm_bank: duty writes and enable in, PWM outputs and period strobe out.
interface pwm_bank_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 8
);
    localparam int unsigned AW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                enable;
    logic [WIDTH-1:0]    controlInput;
    logic [AW-1:0]       loadAddr;
    logic                load;
    logic [CHANNELS-1:0] pwmOut;
    logic                periodStart;

    modport master (
        output enable, controlInput, loadAddr, load,
        input  pwmOut, periodStart
    );

    modport slave (
        input  enable, controlInput, loadAddr, load,
        output pwmOut, periodStart
    );
endinterface

// File: rtl/pwm_bank.sv
// Multi-channel double-buffered PWM: shadow duty registers are copied to the active set at
// each period boundary (or continuously while disabled), giving glitch-free duty updates.
`ifndef K1_25_PWM_STEP
`define K1_25_PWM_STEP 25
`endif

module pwm_bank #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = `K1_25_PWM_STEP,
    parameter bit          INVERT   = 1'b0
) (
    input  logic      masterClk,
    input  logic      rst,
    pwm_bank_if.slave bus
);
    localparam int unsigned MAX_STEP = (1 << WIDTH) - 1;
    localparam int unsigned PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]    pre_cnt;
    logic [WIDTH-1:0] step_cnt;
    logic [WIDTH-1:0] shadow [CHANNELS];
    logic [WIDTH-1:0] active [CHANNELS];
    logic             prev_load;
    logic             tick;
    logic             boundary;
    logic             write;

    // Step tick, last-step-of-period detect and rising-edge write qualification.
    always_comb begin
        tick     = 1'b0;
        boundary = 1'b0;
        write    = 1'b0;
        tick     = bus.enable && (pre_cnt == PW'(PRESCALE - 1));
        boundary = tick && (step_cnt == WIDTH'(MAX_STEP - 1));
        write    = bus.load && !prev_load && (32'(bus.loadAddr) < CHANNELS);
    end

    always_ff @(posedge masterClk or posedge rst) begin
        if (rst) begin
            pre_cnt         <= '0;
            step_cnt        <= '0;
            prev_load       <= 1'b0;
            bus.pwmOut      <= {CHANNELS{INVERT}};
            bus.periodStart <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            prev_load <= bus.load;
            if (!bus.enable) begin
                pre_cnt         <= '0;
                step_cnt        <= '0;
                bus.pwmOut      <= {CHANNELS{INVERT}};
                bus.periodStart <= 1'b0;
                for (int i = 0; i < CHANNELS; i++) begin
                    active[i] <= shadow[i];
                end
            end else begin
                pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
                if (tick) begin
                    step_cnt <= (step_cnt == WIDTH'(MAX_STEP - 1)) ? '0 : step_cnt + WIDTH'(1);
                end
                bus.periodStart <= boundary;
                // Comparison uses pre-boundary values, so the new duty starts on the next step.
                for (int i = 0; i < CHANNELS; i++) begin
                    if (boundary) begin
                        active[i] <= shadow[i];
                    end
                    bus.pwmOut[i] <= INVERT ^ (step_cnt < active[i]);
                end
            end
            if (write) begin
                shadow[bus.loadAddr] <= bus.controlInput;
            end
        end
    end
endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank: three instances (4ch, 3ch, 4ch inverted) checked every cycle against a
// period-arithmetic reference model, plus directed high-time measurements.
module tb_pwm_bank;
    localparam int P   = 2;
    localparam int MX  = 15;
    localparam int PER = MX * P;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]      rst_v = 3'b111;
    logic [2:0]      en    = 3'b111;
    logic [2:0]      ld    = 3'b000;
    logic [2:0][3:0] din   = '0;
    logic [2:0][1:0] addr  = '0;
    logic [2:0][3:0] obs;
    logic [2:0]      ps;

    int n_checks = 0;
    int n_err    = 0;

    int ch_n [3] = '{4, 3, 4};
    bit inv  [3] = '{1'b0, 1'b0, 1'b1};

    pwm_bank_if #(.CHANNELS(4), .WIDTH(4)) if_a ();
    pwm_bank_if #(.CHANNELS(3), .WIDTH(4)) if_b ();
    pwm_bank_if #(.CHANNELS(4), .WIDTH(4)) if_c ();

    assign if_a.enable = en[0]; assign if_a.load = ld[0];
    assign if_a.controlInput = din[0]; assign if_a.loadAddr = addr[0];
    assign if_b.enable = en[1]; assign if_b.load = ld[1];
    assign if_b.controlInput = din[1]; assign if_b.loadAddr = addr[1];
    assign if_c.enable = en[2]; assign if_c.load = ld[2];
    assign if_c.controlInput = din[2]; assign if_c.loadAddr = addr[2];
    assign obs[0] = if_a.pwmOut;
    assign obs[1] = {1'b0, if_b.pwmOut};
    assign obs[2] = if_c.pwmOut;
    assign ps[0] = if_a.periodStart;
    assign ps[1] = if_b.periodStart;
    assign ps[2] = if_c.periodStart;

    pwm_bank #(.CHANNELS(4), .WIDTH(4), .PRESCALE(2), .INVERT(1'b0)) dut_a (
        .masterClk(clk), .rst(rst_v[0]), .bus(if_a));
    pwm_bank #(.CHANNELS(3), .WIDTH(4), .PRESCALE(2), .INVERT(1'b0)) dut_b (
        .masterClk(clk), .rst(rst_v[1]), .bus(if_b));
    pwm_bank #(.CHANNELS(4), .WIDTH(4), .PRESCALE(2), .INVERT(1'b1)) dut_c (
        .masterClk(clk), .rst(rst_v[2]), .bus(if_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: position in the period derived from the count of enabled cycles.
    int         m_k    [3];
    logic [3:0] m_sh   [3][4];
    logic [3:0] m_ac   [3][4];
    logic       m_prev [3];
    logic [3:0] m_pwm  [3];
    logic       m_ps   [3];

    function automatic logic [3:0] idle_val(input int j);
        return inv[j] ? 4'hF : 4'h0;
    endfunction

    task automatic model_step(input int j);
        int  step;
        bit  bnd;
        if (rst_v[j]) begin
            m_k[j] = 0; m_prev[j] = 1'b0; m_ps[j] = 1'b0; m_pwm[j] = idle_val(j);
            for (int i = 0; i < 4; i++) begin m_sh[j][i] = 4'h0; m_ac[j][i] = 4'h0; end
        end else begin
            step = (m_k[j] / P) % MX;
            bnd  = en[j] && ((m_k[j] % PER) == PER - 1);
            m_pwm[j] = 4'h0;
            for (int i = 0; i < ch_n[j]; i++)
                m_pwm[j][i] = inv[j] ^ (en[j] && (step < int'(m_ac[j][i])));
            m_ps[j] = bnd;
            for (int i = 0; i < ch_n[j]; i++)
                if (!en[j] || bnd) m_ac[j][i] = m_sh[j][i];
            m_k[j] = en[j] ? m_k[j] + 1 : 0;
            if (ld[j] && !m_prev[j] && int'(addr[j]) < ch_n[j]) m_sh[j][addr[j]] = din[j];
            m_prev[j] = ld[j];
        end
    endtask

    initial for (int j = 0; j < 3; j++) begin
        m_k[j] = 0; m_prev[j] = 1'b0; m_ps[j] = 1'b0; m_pwm[j] = idle_val(j);
    end

    always @(posedge clk) for (int j = 0; j < 3; j++) model_step(j);

    always @(negedge clk) begin
        for (int j = 0; j < 3; j++) begin
            check($sformatf("pwm%0d", j), 32'(obs[j]), 32'(rst_v[j] ? idle_val(j) : m_pwm[j]));
            check($sformatf("pstart%0d", j), 32'(ps[j]), 32'(rst_v[j] ? 1'b0 : m_ps[j]));
        end
    end

    task automatic wr(input int j, input logic [1:0] a, input logic [3:0] d);
        @(negedge clk); addr[j] = a; din[j] = d; ld[j] = 1'b1;
        @(negedge clk); ld[j] = 1'b0;
    endtask

    task automatic wait_ps(input int j);
        int n = 0;
        do begin @(negedge clk); n++; end while (!ps[j] && n < 100);
        check($sformatf("ps_seen%0d", j), 32'(ps[j]), 32'd1);
    endtask

    // Counts high cycles of one channel over one period; optional write at cycle wr_at.
    task automatic measure(input int j, input int ch, input int wr_at, input logic [1:0] wa,
                           input logic [3:0] wd, output int highs, output int ps_at);
        highs = 0; ps_at = 0;
        for (int i = 1; i <= PER; i++) begin
            @(negedge clk);
            if (obs[j][ch]) highs++;
            if (ps[j] && ps_at == 0) ps_at = i;
            if (i == wr_at) begin addr[j] = wa; din[j] = wd; ld[j] = 1'b1; end
            else if (i == wr_at + 1) ld[j] = 1'b0;
        end
    endtask

    initial begin
        int h, pa;
        repeat (3) @(negedge clk);
        #3 rst_v = 3'b000;

        // Instance A: basic duties, mid-period and boundary-cycle writes, enable gap.
        wr(0, 2'd0, 4'd5); wr(0, 2'd1, 4'd0); wr(0, 2'd2, 4'd15);
        wait_ps(0);
        measure(0, 0, -1, 2'd0, 4'd0, h, pa); check("a_ch0_duty5", h, 10); check("a_period", pa, PER);
        measure(0, 1, -1, 2'd0, 4'd0, h, pa); check("a_ch1_duty0", h, 0);
        measure(0, 2, -1, 2'd0, 4'd0, h, pa); check("a_ch2_duty15", h, PER);
        measure(0, 0, 5, 2'd0, 4'd8, h, pa);  check("a_ch0_pre8", h, 10);
        measure(0, 0, 10, 2'd0, 4'd3, h, pa); check("a_ch0_keep8", h, 16);
        measure(0, 0, -1, 2'd0, 4'd0, h, pa); check("a_ch0_new3", h, 6);
        measure(0, 3, 29, 2'd3, 4'd7, h, pa); check("a_ch3_before", h, 0);
        measure(0, 3, -1, 2'd0, 4'd0, h, pa); check("a_ch3_old", h, 0);
        measure(0, 3, -1, 2'd0, 4'd0, h, pa); check("a_ch3_new7", h, 14);
        @(negedge clk); en[0] = 1'b0;
        wr(0, 2'd1, 4'd9);
        repeat (7) @(negedge clk);
        check("a_dis_out", 32'(obs[0]), 32'd0); check("a_dis_ps", 32'(ps[0]), 32'd0);
        @(negedge clk); en[0] = 1'b1;
        measure(0, 1, -1, 2'd0, 4'd0, h, pa); check("a_ch1_en9", h, 18); check("a_en_period", pa, PER);

        // Instance B: held load stores only the edge value; out-of-range address ignored.
        @(negedge clk); addr[1] = 2'd1; din[1] = 4'd6; ld[1] = 1'b1;
        repeat (4) begin @(negedge clk); din[1] = 4'($urandom_range(0, 15)); end
        @(negedge clk); ld[1] = 1'b0;
        wait_ps(1);
        measure(1, 1, -1, 2'd0, 4'd0, h, pa); check("b_hold6", h, 12);
        wr(1, 2'd3, 4'd9);
        wait_ps(1);
        measure(1, 1, -1, 2'd0, 4'd0, h, pa); check("b_ch1_keep", h, 12);
        measure(1, 2, -1, 2'd0, 4'd0, h, pa); check("b_ch2_keep", h, 0);
        measure(1, 0, -1, 2'd0, 4'd0, h, pa); check("b_ch0_keep", h, 0);

        // Instance C: inverted outputs and asynchronous reset mid-period.
        wr(2, 2'd0, 4'd15); wr(2, 2'd1, 4'd0);
        wait_ps(2);
        repeat (7) @(negedge clk);
        check("c_inv_out", 32'(obs[2][1:0]), 32'h2);
        #3 rst_v[2] = 1'b1;
        #1 check("c_async_rst", 32'(obs[2]), 32'hF);
        repeat (3) @(negedge clk);
        #3 rst_v[2] = 1'b0;

        // Randomized traffic on all instances, with periodic resets of A.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            if (cyc % 500 == 250) begin
                #3 rst_v[0] = 1'b1;
                @(negedge clk); #3 rst_v[0] = 1'b0;
            end
            for (int j = 0; j < 3; j++) begin
                int r = int'($urandom_range(0, 99));
                din[j]  = 4'($urandom_range(0, 15));
                addr[j] = 2'($urandom_range(0, 3));
                if (r < 10) ld[j] = ~ld[j];
                if (r == 50 || r == 51) en[j] = ~en[j];
            end
        end
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
